tile_map_engine: RTL and testbench

Parametrised tile-map display engine: owns a single-port tile RAM of 2^ROWS_LOG2 x 2^COLS_LOG2 cells and loads it row by row from a bitmask map source under a handshake. It renders the map into a pipelined pixel stream from hvsync_generator timing, with tile-granular wrap-around scrolling and per-cell colour. A host write port, arbitrated against display reads, edits cells. Sits between hvsync_generator, the map ROM and the glyph (tile shape) lookup in the top level.

---
 rtl/tile_map_engine_if.sv | 42 ++++
 rtl/tile_map_engine.sv | 161 ++++++++++++++++
 tb/tb_tile_map_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_engine_if.sv
// Signal bundle between the tile-map engine and its surroundings:
// beam timing, map-source handshake, host write port, glyph lookup, pixel out.
interface tile_map_engine_if #(
  parameter int COLS_LOG2 = 5,
  parameter int ROWS_LOG2 = 5,
  parameter int DATA_W    = 8
);
  localparam int NCOLS = 1 << COLS_LOG2;

  logic [9:0]                     hpos;
  logic [9:0]                     vpos;
  logic                           display_on;
  logic                           init_start;
  logic [ROWS_LOG2-1:0]           src_row;
  logic [NCOLS-1:0]               src_bits;
  logic                           src_valid;
  logic                           busy;
  logic                           host_we;
  logic [ROWS_LOG2+COLS_LOG2-1:0] host_addr;
  logic [DATA_W-1:0]              host_din;
  logic                           host_ack;
  logic [COLS_LOG2-1:0]           scroll_x;
  logic [ROWS_LOG2-1:0]           scroll_y;
  logic [1:0]                     glyph_type;
  logic [1:0]                     glyph_rot;
  logic [2:0]                     glyph_x;
  logic [2:0]                     glyph_y;
  logic                           glyph_bit;
  logic [2:0]                     rgb;

  modport slave (
    input  hpos, vpos, display_on, init_start, src_bits, src_valid,
           host_we, host_addr, host_din, scroll_x, scroll_y, glyph_bit,
    output src_row, busy, host_ack, glyph_type, glyph_rot, glyph_x, glyph_y, rgb
  );

  modport master (
    output hpos, vpos, display_on, init_start, src_bits, src_valid,
           host_we, host_addr, host_din, scroll_x, scroll_y, glyph_bit,
    input  src_row, busy, host_ack, glyph_type, glyph_rot, glyph_x, glyph_y, rgb
  );
endinterface

// File: rtl/tile_map_engine.sv
// Tile-map display engine: single-port tile RAM loaded row by row from a bitmask
// source, edited by a host port, and rendered with wrap-around scrolling.
module tile_map_engine #(
  parameter int COLS_LOG2 = 5,
  parameter int ROWS_LOG2 = 5,
  parameter int TILE_LOG2 = 4,
  parameter int DATA_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tile_map_engine_if.slave bus
);
  localparam int NCOLS = 1 << COLS_LOG2;
  localparam int AW    = ROWS_LOG2 + COLS_LOG2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t               r_state, w_state_nxt;
  logic [ROWS_LOG2-1:0] r_row, w_row_nxt;
  logic [COLS_LOG2-1:0] r_col, w_col_nxt;
  logic [NCOLS-1:0]     r_bits, w_bits_nxt;
  logic                 r_ack;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]    r_rd;
  logic [2:0]           r_gx, r_gy;
  logic                 r_don1, r_clip1;
  logic [1:0]           r_vld_pipe;
  logic [2:0]           r_rgb;

  logic                 w_busy, w_ld_we, w_host_go, w_disp_rd, w_ram_we, w_clip;
  logic [AW-1:0]        w_ram_addr;
  logic [DATA_W-1:0]    w_ram_din;
  logic [9:0]           w_tc, w_tr;
  logic [COLS_LOG2-1:0] w_dcol;
  logic [ROWS_LOG2-1:0] w_drow;
  logic [2:0]           w_colour;
  logic                 w_unused;

  // ---------------- loader FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_bits  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_bits  <= w_bits_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_bits_nxt  = r_bits;
    unique case (r_state)
      IDLE: if (bus.init_start) begin
        w_state_nxt = REQ;
        w_row_nxt   = '0;
      end
      REQ: if (bus.src_valid) begin
        w_bits_nxt  = bus.src_bits;
        w_col_nxt   = '0;
        w_state_nxt = FILL;
      end
      FILL: begin
        w_col_nxt = r_col + 1'b1;
        if (r_col == '1) begin
          if (r_row == '1) begin
            w_state_nxt = IDLE;
          end else begin
            w_row_nxt   = r_row + 1'b1;
            w_state_nxt = REQ;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy  = (r_state != IDLE);
  assign w_ld_we = (r_state == FILL);

  // Column c lives at bit NCOLS-1-c, which is simply bit ~c.
  // The ~r_ack term stops a still-held host_we from writing twice.
  assign w_host_go = bus.host_we & ~r_ack & ~w_busy & ~bus.display_on;

  // ---------------- display address ----------------
  assign w_tc   = bus.hpos >> TILE_LOG2;
  assign w_tr   = bus.vpos >> TILE_LOG2;
  assign w_clip = (|(w_tc >> COLS_LOG2)) | (|(w_tr >> ROWS_LOG2));
  assign w_dcol = w_tc[COLS_LOG2-1:0] + bus.scroll_x;
  assign w_drow = w_tr[ROWS_LOG2-1:0] + bus.scroll_y;

  // ---------------- single RAM port: loader > host > display ----------------
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = {w_drow, w_dcol};
    w_ram_din  = '0;
    w_disp_rd  = 1'b1;
    if (w_ld_we) begin
      w_ram_we   = 1'b1;
      w_ram_addr = {r_row, r_col};
      w_ram_din  = {{(DATA_W-1){1'b0}}, r_bits[~r_col]};
      w_disp_rd  = 1'b0;
    end else if (w_host_go) begin
      w_ram_we   = 1'b1;
      w_ram_addr = bus.host_addr;
      w_ram_din  = bus.host_din;
      w_disp_rd  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_din;
  end

  // ---------------- pixel pipeline ----------------
  assign w_colour = (r_rd[6:4] == 3'b000) ? 3'b100 : r_rd[6:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd       <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_don1     <= 1'b0;
      r_clip1    <= 1'b0;
      r_vld_pipe <= '0;
      r_rgb      <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_rd       <= r_mem[w_ram_addr];
      r_gx       <= bus.hpos[TILE_LOG2-1 -: 3];
      r_gy       <= bus.vpos[TILE_LOG2-1 -: 3];
      r_don1     <= bus.display_on;
      r_clip1    <= w_clip;
      r_vld_pipe <= {r_vld_pipe[0], w_disp_rd};
      r_rgb      <= (r_vld_pipe[0] & r_don1 & ~r_clip1 & bus.glyph_bit) ? w_colour : 3'b000;
      r_ack      <= w_host_go;
    end
  end

  // ---------------- outputs ----------------
  assign bus.busy       = w_busy;
  assign bus.src_row    = r_row;
  assign bus.host_ack   = r_ack;
  assign bus.glyph_type = r_rd[1:0];
  assign bus.glyph_rot  = r_rd[3:2];
  assign bus.glyph_x    = r_gx;
  assign bus.glyph_y    = r_gy;
  assign bus.rgb        = (r_vld_pipe[1] & ~w_busy) ? r_rgb : 3'b000;

  // Reserved cell bits and sub-glyph beam bits are deliberately ignored.
  assign w_unused = ^{r_rd, bus.hpos, bus.vpos};

endmodule

// File: tb/tb_tile_map_engine.sv
// Directed bench for tile_map_engine: reset, map load, readback through the
// pixel pipeline, host arbitration, table-driven render/scroll vectors, reset mid-load.
module tb_tile_map_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_map_engine_if #(.COLS_LOG2(5), .ROWS_LOG2(5), .DATA_W(8)) bus ();

  tile_map_engine #(.COLS_LOG2(5), .ROWS_LOG2(5), .TILE_LOG2(4), .DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;
  int ack_cnt = 0;

  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.host_ack === 1'b1) ack_cnt++;
  end

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [4:0] sx;
    logic [4:0] sy;
    logic       don;
    logic       gbit;
    logic [1:0] typ;
    logic [1:0] rot;
    logic [2:0] gx;
    logic [2:0] gy;
    logic [2:0] rgb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input vec_t v, input int idx);
    bus.hpos = v.h; bus.vpos = v.v;
    bus.scroll_x = v.sx; bus.scroll_y = v.sy;
    bus.display_on = v.don; bus.glyph_bit = v.gbit;
    tick();
    chk($sformatf("v%0d glyph_type", idx), bus.glyph_type, v.typ);
    chk($sformatf("v%0d glyph_rot", idx), bus.glyph_rot, v.rot);
    chk($sformatf("v%0d glyph_x", idx), bus.glyph_x, v.gx);
    chk($sformatf("v%0d glyph_y", idx), bus.glyph_y, v.gy);
    tick();
    chk($sformatf("v%0d rgb", idx), bus.rgb, v.rgb);
  endtask

  task automatic host_write(input logic [9:0] a, input logic [7:0] d, input string nm);
    bit got = 0;
    bus.host_addr = a; bus.host_din = d; bus.host_we = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.host_ack) got = 1;
    end
    bus.host_we = 1'b0;
    chk(nm, int'(got), 1);
  endtask

  // Source model: src_valid three cycles into each REQ, bitmask 8000_0001.
  task automatic load_rows(input int nrows, input bit checks);
    bus.init_start = 1'b1;
    if (checks) chk("busy before rise", bus.busy, 0);
    tick();
    bus.init_start = 1'b0;
    if (checks) chk("busy rises", bus.busy, 1);
    for (int r = 0; r < nrows; r++) begin
      if (checks) chk($sformatf("src_row r%0d", r), bus.src_row, r);
      repeat (3) tick();
      if (checks) chk($sformatf("rgb forced r%0d", r), bus.rgb, 0);
      bus.src_bits = 32'h8000_0001; bus.src_valid = 1'b1;
      tick();
      bus.src_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (r == 2 && i == 5) bus.init_start = 1'b1;
        tick();
        bus.init_start = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{10'd48,  10'd32,  5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 2'd1, 3'd0, 3'd0, 3'b010};
    vecs[1]  = '{10'd54,  10'd42,  5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 2'd1, 3'd3, 3'd5, 3'b010};
    vecs[2]  = '{10'd48,  10'd32,  5'd0,  5'd0,  1'b1, 1'b0, 2'd1, 2'd1, 3'd0, 3'd0, 3'b000};
    vecs[3]  = '{10'd48,  10'd32,  5'd0,  5'd0,  1'b0, 1'b1, 2'd1, 2'd1, 3'd0, 3'd0, 3'b000};
    vecs[4]  = '{10'd512, 10'd32,  5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 2'd0, 3'd0, 3'd0, 3'b000};
    vecs[5]  = '{10'd0,   10'd0,   5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 2'd0, 3'd0, 3'd0, 3'b100};
    vecs[6]  = '{10'd16,  10'd0,   5'd0,  5'd0,  1'b1, 1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 3'b100};
    vecs[7]  = '{10'd0,   10'd512, 5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 2'd0, 3'd0, 3'd0, 3'b000};
    vecs[8]  = '{10'd0,   10'd0,   5'd31, 5'd1,  1'b1, 1'b1, 2'd2, 2'd3, 3'd0, 3'd0, 3'b011};
    vecs[9]  = '{10'd32,  10'd32,  5'd1,  5'd0,  1'b1, 1'b1, 2'd1, 2'd1, 3'd0, 3'd0, 3'b010};
    vecs[10] = '{10'd496, 10'd48,  5'd31, 5'd31, 1'b1, 1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 3'b100};
    vecs[11] = '{10'd48,  10'd32,  5'd29, 5'd0,  1'b1, 1'b1, 2'd1, 2'd0, 3'd0, 3'd0, 3'b100};
    vecs[12] = '{10'd511, 10'd511, 5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 2'd0, 3'd7, 3'd7, 3'b100};

    bus.hpos = '0; bus.vpos = '0; bus.display_on = 1'b0; bus.init_start = 1'b0;
    bus.src_bits = '0; bus.src_valid = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0;
    bus.host_din = '0; bus.scroll_x = '0; bus.scroll_y = '0; bus.glyph_bit = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset busy", bus.busy, 0);
    chk("reset host_ack", bus.host_ack, 0);
    chk("reset src_row", bus.src_row, 0);
    chk("reset rgb", bus.rgb, 0);
    chk("reset glyph_type", bus.glyph_type, 0);
    chk("reset glyph_rot", bus.glyph_rot, 0);
    chk("reset glyph_x", bus.glyph_x, 0);
    chk("reset glyph_y", bus.glyph_y, 0);
    rst_n = 1'b1;
    tick();

    // src_valid in IDLE is ignored
    bus.src_bits = 32'hFFFF_FFFF; bus.src_valid = 1'b1;
    repeat (3) tick();
    bus.src_valid = 1'b0;
    chk("idle src_valid busy", bus.busy, 0);
    chk("idle src_valid src_row", bus.src_row, 0);

    // Full load with display active and a host write pending throughout
    bus.display_on = 1'b1; bus.glyph_bit = 1'b1;
    bus.host_addr = {5'd2, 5'd3}; bus.host_din = 8'h25; bus.host_we = 1'b1;
    busy_cnt = 0; ack_cnt = 0;
    load_rows(32, 1'b1);
    chk("busy falls", bus.busy, 0);
    chk("busy cycles", busy_cnt, 32 * 36);

    // Readback every cell through the pipeline (host still blocked by display_on)
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        bus.hpos = 10'(c * 16); bus.vpos = 10'(r * 16);
        tick();
        chk($sformatf("load cell %0d,%0d", r, c), bus.glyph_type, (c == 0 || c == 31) ? 1 : 0);
      end
    end
    chk("no ack while busy/display", ack_cnt, 0);

    // display_on falls: write happens, ack one cycle later, single pulse
    bus.display_on = 1'b0;
    chk("ack not yet", bus.host_ack, 0);
    tick();
    chk("ack after display off", bus.host_ack, 1);
    bus.host_we = 1'b0;
    tick();
    chk("ack one cycle", bus.host_ack, 0);
    chk("ack count", ack_cnt, 1);

    host_write({5'd1, 5'd31}, 8'h3E, "host write 1,31");

    // Render / clip / scroll vectors
    for (int i = 0; i < 13; i++) probe(vecs[i], i);

    // Reset mid-load at row 5, column 10
    bus.scroll_x = '0; bus.scroll_y = '0; bus.hpos = '0; bus.vpos = '0;
    bus.display_on = 1'b1; bus.glyph_bit = 1'b1;
    load_rows(5, 1'b0);
    chk("mid src_row 5", bus.src_row, 5);
    repeat (3) tick();
    bus.src_valid = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    repeat (10) tick();
    chk("mid busy before reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset rgb", bus.rgb, 0);
    chk("mid reset src_row", bus.src_row, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post reset idle", bus.busy, 0);
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    chk("restart busy", bus.busy, 1);
    chk("restart src_row", bus.src_row, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
